// File: rtl/pkt_out_arbiter.sv
// pkt_out_arbiter: merges N per-instance output streams into one output_fifo.
// Packets are forwarded atomically. Grants rotate round-robin and start after
// the channel that was served last. A word-count watchdog traps runaway
// packets into a sticky error state. idle tells the clock-gating logic that
// the merger has no work to do.
module pkt_out_arbiter #(
    parameter  int N_CHANNELS    = 4,
    parameter  int WIDTH         = 16,
    parameter  int MAX_PKT_WORDS = 1024,
    localparam int GW            = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int CW            = $clog2(MAX_PKT_WORDS + 1)
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic [N_CHANNELS*WIDTH-1:0]  din,
    input  logic [N_CHANNELS-1:0]        din_last,
    input  logic [N_CHANNELS-1:0]        empty,
    output logic [N_CHANNELS-1:0]        rd_en,
    output logic [WIDTH-1:0]             dout,
    output logic                         wr_en,
    input  logic                         full,
    output logic [GW-1:0]                grant_chan,
    output logic                         idle,
    output logic                         error,
    output logic [GW-1:0]                err_chan
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_XFER   = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [GW-1:0]      grant_r;
    logic [GW-1:0]      grant_nxt_s;
    logic [GW-1:0]      err_chan_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   dout_r;
    logic               wr_en_r;
    logic               idle_r;
    logic               error_r;

    logic               found_s;
    logic [GW-1:0]      scan_sel_s;
    logic               rd_s;
    logic               err_hit_s;
    logic [WIDTH-1:0]   din_g_s;
    logic               last_g_s;
    logic               empty_g_s;
    logic               at_limit_s;

    // Source signals of the channel that currently holds the grant.
    always_comb begin
        din_g_s    = din[grant_r*WIDTH +: WIDTH];
        last_g_s   = din_last[grant_r];
        empty_g_s  = empty[grant_r];
        at_limit_s = (cnt_r == CW'(MAX_PKT_WORDS - 1));
    end

    // Round-robin scan: find the first non-empty channel after the last grant.
    always_comb begin
        logic [GW-1:0] idx_v;
        idx_v      = '0;
        found_s    = 1'b0;
        scan_sel_s = grant_r;
        for (int i = 1; i <= N_CHANNELS; i++) begin
            idx_v = GW'((int'(grant_r) + i) % N_CHANNELS);
            if (!found_s && !empty[idx_v]) begin
                found_s    = 1'b1;
                scan_sel_s = idx_v;
            end else begin
                found_s    = found_s;
            end
        end
    end

    // Next state, grant update and the read decision for the granted channel.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        rd_s        = 1'b0;
        err_hit_s   = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                if (found_s) begin
                    grant_nxt_s = scan_sel_s;
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_XFER: begin
                rd_s = ~empty_g_s & ~full;
                if (rd_s && last_g_s) begin
                    state_nxt_s = ST_SEARCH;
                end else if (rd_s && at_limit_s) begin
                    state_nxt_s = ST_ERR;
                    err_hit_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s = ST_SEARCH;
            end
        endcase
    end

    // Read strobe goes only to the granted channel; it follows full combinationally.
    always_comb begin
        rd_en          = {N_CHANNELS{1'b0}};
        rd_en[grant_r] = rd_s;
    end

    // FSM state and grant registers; grant_chan starts on the last channel so
    // the first scan after reset begins at channel 0.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= ST_SEARCH;
            grant_r <= GW'(N_CHANNELS - 1);
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
        end
    end

    // Output word register, packet length counter, sticky error and idle flag.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dout_r     <= {WIDTH{1'b0}};
            wr_en_r    <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            error_r    <= 1'b0;
            err_chan_r <= {GW{1'b0}};
            idle_r     <= 1'b1;
        end else begin
            if (rd_s) begin
                dout_r  <= din_g_s;
                wr_en_r <= 1'b1;
                cnt_r   <= last_g_s ? {CW{1'b0}} : (cnt_r + CW'(1));
            end else begin
                wr_en_r <= 1'b0;
            end
            if (err_hit_s) begin
                error_r    <= 1'b1;
                err_chan_r <= grant_r;
            end else begin
                error_r    <= error_r;
            end
            // ERR never satisfies the SEARCH term, which keeps idle low there.
            idle_r <= (state_r == ST_SEARCH) && (&empty) && !wr_en_r;
        end
    end

    assign dout       = dout_r;
    assign wr_en      = wr_en_r;
    assign grant_chan = grant_r;
    assign idle       = idle_r;
    assign error      = error_r;
    assign err_chan   = err_chan_r;

endmodule

// File: tb/tb_pkt_out_arbiter.sv
// Directed testbench for pkt_out_arbiter (4 channels, 16-bit, 8-word packet limit).
module tb_pkt_out_arbiter;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int MAXW = 8;

    localparam logic [17:0] EXP_F [12] = '{
        18'h00A01, 18'h00A02, 18'h10B01, 18'h10B02, 18'h30D01, 18'h30D02,
        18'h00A03, 18'h00A04, 18'h10B03, 18'h10B04, 18'h30D03, 18'h30D04 };
    localparam logic [17:0] EXP_S [6] = '{
        18'h00C01, 18'h00C02, 18'h00C03, 18'h00C04, 18'h10E01, 18'h10E02 };

    logic           CLK = 1'b0;
    logic           RESET_N;
    logic [N*W-1:0] din;
    logic [N-1:0]   din_last;
    logic [N-1:0]   empty;
    logic [N-1:0]   rd_en;
    logic [W-1:0]   dout;
    logic           wr_en;
    logic           full;
    logic [1:0]     grant_chan;
    logic           idle;
    logic           error;
    logic [1:0]     err_chan;

    logic [16:0]    q0[$], q1[$], q2[$], q3[$];
    logic [N-1:0]   hold_mask;
    logic [N-1:0]   rd_cap;
    int             pop_cnt[4];
    logic [17:0]    log_q[$];
    int             n_checks;
    int             n_fail;

    pkt_out_arbiter #(.N_CHANNELS(N), .WIDTH(W), .MAX_PKT_WORDS(MAXW)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .din(din), .din_last(din_last), .empty(empty),
        .rd_en(rd_en), .dout(dout), .wr_en(wr_en), .full(full), .grant_chan(grant_chan),
        .idle(idle), .error(error), .err_chan(err_chan));

    always #5 CLK = ~CLK;

    function automatic int q_size(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            3: return q3.size();
            default: return 0;
        endcase
    endfunction

    function automatic logic [16:0] q_front(input int k);
        if (q_size(k) == 0) return 17'h0;
        case (k)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            3: return q3[0];
            default: return 17'h0;
        endcase
    endfunction

    task automatic q_push(input int k, input logic last, input logic [15:0] d);
        case (k)
            0: q0.push_back({last, d});
            1: q1.push_back({last, d});
            2: q2.push_back({last, d});
            default: q3.push_back({last, d});
        endcase
    endtask

    task automatic q_pop(input int k);
        if (q_size(k) > 0) begin
            case (k)
                0: q0.delete(0);
                1: q1.delete(0);
                2: q2.delete(0);
                default: q3.delete(0);
            endcase
        end
    endtask

    // Present FWFT source state to the DUT.
    task automatic drive_inputs();
        logic [16:0] f;
        for (int k = 0; k < N; k++) begin
            f = q_front(k);
            empty[k]         = (q_size(k) == 0) || hold_mask[k];
            din[k*W +: W]    = f[15:0];
            din_last[k]      = f[16];
        end
    endtask

    // One clock: drive, capture rd_en, clock edge, consume reads, log writes.
    task automatic tick();
        drive_inputs();
        #1;
        rd_cap = rd_en;
        @(posedge CLK);
        #1;
        for (int k = 0; k < N; k++) begin
            if (rd_cap[k]) begin
                q_pop(k);
                pop_cnt[k]++;
            end
        end
        if (wr_en) log_q.push_back({grant_chan, dout});
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        hold_mask = 4'b0000;
        full      = 1'b0;
        drive_inputs();
        log_q.delete();
        pop_cnt = '{default: 0};
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (rd_en !== 4'b0000) begin n_fail++; $display("FAIL reset_rd_en got %b want 0000", rd_en); end
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout got %h want 0000", dout); end
        n_checks++; if (grant_chan !== 2'd3) begin n_fail++; $display("FAIL reset_grant got %0d want 3", grant_chan); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
        n_checks++; if (err_chan !== 2'd0) begin n_fail++; $display("FAIL reset_err_chan got %0d want 0", err_chan); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", idle); end
    endtask

    task automatic test_single_packet();
        do_reset();
        q_push(2, 1'b0, 16'h1111);
        q_push(2, 1'b0, 16'h2222);
        q_push(2, 1'b1, 16'h3333);
        tick();
        n_checks++; if (rd_cap !== 4'b0000) begin n_fail++; $display("FAIL single_search_rd got %b want 0000", rd_cap); end
        n_checks++; if (grant_chan !== 2'd2) begin n_fail++; $display("FAIL single_grant got %0d want 2", grant_chan); end
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL single_search_wr got %b want 0", wr_en); end
        tick();
        n_checks++; if (rd_cap !== 4'b0100) begin n_fail++; $display("FAIL single_rd_en got %b want 0100", rd_cap); end
        n_checks++; if ({wr_en, dout} !== {1'b1, 16'h1111}) begin n_fail++; $display("FAIL single_w1 got %b/%h want 1/1111", wr_en, dout); end
        tick();
        n_checks++; if ({wr_en, dout} !== {1'b1, 16'h2222}) begin n_fail++; $display("FAIL single_w2 got %b/%h want 1/2222", wr_en, dout); end
        tick();
        n_checks++; if ({wr_en, dout} !== {1'b1, 16'h3333}) begin n_fail++; $display("FAIL single_w3 got %b/%h want 1/3333", wr_en, dout); end
        tick();
        n_checks++; if ({wr_en, idle} !== 2'b00) begin n_fail++; $display("FAIL single_after_wr_idle got %b%b want 00", wr_en, idle); end
        tick();
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle_back got %b want 1", idle); end
    endtask

    task automatic test_fairness();
        do_reset();
        q_push(0, 1'b0, 16'h0A01); q_push(0, 1'b1, 16'h0A02); q_push(0, 1'b0, 16'h0A03); q_push(0, 1'b1, 16'h0A04);
        q_push(1, 1'b0, 16'h0B01); q_push(1, 1'b1, 16'h0B02); q_push(1, 1'b0, 16'h0B03); q_push(1, 1'b1, 16'h0B04);
        q_push(3, 1'b0, 16'h0D01); q_push(3, 1'b1, 16'h0D02); q_push(3, 1'b0, 16'h0D03); q_push(3, 1'b1, 16'h0D04);
        for (int n = 0; n < 100 && log_q.size() < 12; n++) tick();
        n_checks++; if (log_q.size() != 12) begin n_fail++; $display("FAIL fair_count got %0d want 12", log_q.size()); end
        for (int i = 0; i < 12 && i < log_q.size(); i++) begin
            n_checks++; if (log_q[i] !== EXP_F[i]) begin n_fail++; $display("FAIL fair_word%0d got %h want %h", i, log_q[i], EXP_F[i]); end
        end
    endtask

    task automatic test_backpressure();
        int wr_during;
        int rd_bad;
        do_reset();
        for (int i = 1; i <= 6; i++) q_push(1, (i == 6), 16'h1000 + 16'(i));
        for (int n = 0; n < 20 && log_q.size() < 2; n++) tick();
        n_checks++; if (log_q.size() != 2) begin n_fail++; $display("FAIL bp_prefill got %0d want 2", log_q.size()); end
        full = 1'b1;
        wr_during = 0;
        rd_bad    = 0;
        repeat (5) begin
            tick();
            if (wr_en) wr_during++;
            if (rd_cap !== 4'b0000) rd_bad++;
        end
        n_checks++; if (wr_during > 1) begin n_fail++; $display("FAIL bp_wr_after_full got %0d want <=1", wr_during); end
        n_checks++; if (rd_bad != 0) begin n_fail++; $display("FAIL bp_rd_while_full got %0d want 0", rd_bad); end
        full = 1'b0;
        tick();
        n_checks++; if (rd_cap !== 4'b0010) begin n_fail++; $display("FAIL bp_resume_rd got %b want 0010", rd_cap); end
        n_checks++; if ({wr_en, dout} !== {1'b1, 16'h1003}) begin n_fail++; $display("FAIL bp_resume_wr got %b/%h want 1/1003", wr_en, dout); end
        for (int n = 0; n < 40 && log_q.size() < 6; n++) tick();
        n_checks++; if (log_q.size() != 6) begin n_fail++; $display("FAIL bp_count got %0d want 6", log_q.size()); end
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            n_checks++; if (log_q[i] !== {2'd1, 16'h1001 + 16'(i)}) begin n_fail++; $display("FAIL bp_word%0d got %h want %h", i, log_q[i], {2'd1, 16'h1001 + 16'(i)}); end
        end
    endtask

    task automatic test_stall();
        int bad;
        do_reset();
        q_push(0, 1'b0, 16'h0C01); q_push(0, 1'b0, 16'h0C02); q_push(0, 1'b0, 16'h0C03); q_push(0, 1'b1, 16'h0C04);
        q_push(1, 1'b0, 16'h0E01); q_push(1, 1'b1, 16'h0E02);
        for (int n = 0; n < 20 && pop_cnt[0] < 2; n++) tick();
        hold_mask = 4'b0001;
        bad = 0;
        repeat (5) begin
            tick();
            if (rd_cap !== 4'b0000 || grant_chan !== 2'd0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
        hold_mask = 4'b0000;
        for (int n = 0; n < 40 && log_q.size() < 6; n++) tick();
        n_checks++; if (log_q.size() != 6) begin n_fail++; $display("FAIL stall_count got %0d want 6", log_q.size()); end
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            n_checks++; if (log_q[i] !== EXP_S[i]) begin n_fail++; $display("FAIL stall_word%0d got %h want %h", i, log_q[i], EXP_S[i]); end
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 1; i <= 9; i++) q_push(3, 1'b0, 16'h3000 + 16'(i));
        repeat (20) tick();
        n_checks++; if (log_q.size() != 8) begin n_fail++; $display("FAIL wd_count got %0d want 8", log_q.size()); end
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            n_checks++; if (log_q[i] !== {2'd3, 16'h3001 + 16'(i)}) begin n_fail++; $display("FAIL wd_word%0d got %h want %h", i, log_q[i], {2'd3, 16'h3001 + 16'(i)}); end
        end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL wd_error got %b want 1", error); end
        n_checks++; if (err_chan !== 2'd3) begin n_fail++; $display("FAIL wd_err_chan got %0d want 3", err_chan); end
        n_checks++; if (rd_cap !== 4'b0000) begin n_fail++; $display("FAIL wd_rd_en got %b want 0000", rd_cap); end
        n_checks++; if ({wr_en, idle} !== 2'b00) begin n_fail++; $display("FAIL wd_wr_idle got %b%b want 00", wr_en, idle); end
        n_checks++; if (q_size(3) != 1) begin n_fail++; $display("FAIL wd_left got %0d want 1", q_size(3)); end
    endtask

    task automatic test_limit_last();
        do_reset();
        for (int i = 1; i <= 8; i++) q_push(2, (i == 8), 16'h2200 + 16'(i));
        repeat (14) tick();
        n_checks++; if (log_q.size() != 8) begin n_fail++; $display("FAIL lim_count got %0d want 8", log_q.size()); end
        if (log_q.size() == 8) begin
            n_checks++; if (log_q[7] !== {2'd2, 16'h2208}) begin n_fail++; $display("FAIL lim_last got %h want %h", log_q[7], {2'd2, 16'h2208}); end
        end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL lim_error got %b want 0", error); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL lim_idle got %b want 1", idle); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 4; i++) q_push(1, (i == 4), 16'h1100 + 16'(i));
        for (int n = 0; n < 20 && pop_cnt[1] < 2; n++) tick();
        n_checks++; if ({wr_en, dout} !== {1'b1, 16'h1102}) begin n_fail++; $display("FAIL rm_pre got %b/%h want 1/1102", wr_en, dout); end
        #2;
        RESET_N = 1'b0;
        #1;
        n_checks++; if ({wr_en, dout} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL rm_wr_dout got %b/%h want 0/0000", wr_en, dout); end
        n_checks++; if (grant_chan !== 2'd3) begin n_fail++; $display("FAIL rm_grant got %0d want 3", grant_chan); end
        n_checks++; if (rd_en !== 4'b0000) begin n_fail++; $display("FAIL rm_rd_en got %b want 0000", rd_en); end
        n_checks++; if ({idle, error} !== 2'b10) begin n_fail++; $display("FAIL rm_idle_err got %b%b want 10", idle, error); end
        q_push(0, 1'b1, 16'h0F01);
        #1;
        RESET_N = 1'b1;
        tick();
        n_checks++; if (grant_chan !== 2'd0) begin n_fail++; $display("FAIL rm_next_grant got %0d want 0", grant_chan); end
        tick();
        n_checks++; if (rd_cap !== 4'b0001) begin n_fail++; $display("FAIL rm_next_rd got %b want 0001", rd_cap); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        RESET_N   = 1'b0;
        full      = 1'b0;
        hold_mask = 4'b0000;
        din       = '0;
        din_last  = 4'b0000;
        empty     = 4'b1111;
        test_reset();
        test_single_packet();
        test_fairness();
        test_backpressure();
        test_stall();
        test_watchdog();
        test_limit_last();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
